// File: rtl/mem_lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Holds the FSM state enum, RV32I func3 size encodings and byte-enable width.
// Also provides the access-size helper used by the optional misalignment trap.
package mem_lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int BE_W = 4;

  // True when the access size needs more alignment than the low address bits give.
  // Stores only know SB/SH; every other store encoding is a full word.
  function automatic logic misaligned(input logic       is_store,
                                      input logic [2:0] f3,
                                      input logic [1:0] lo);
    logic is_byte;
    logic is_half;
    is_byte = is_store ? (f3 == F3_B) : ((f3 == F3_B) || (f3 == F3_BU));
    is_half = is_store ? (f3 == F3_H) : ((f3 == F3_H) || (f3 == F3_HU));
    if (is_byte)      return 1'b0;
    else if (is_half) return lo[0];
    else              return (lo != 2'b00);
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Lane logic: store byte enables + replicated write data, load lane select + extension.
// Latency: purely combinational.
// Backpressure: none; the parent decides when outputs are sampled.
module lsu_align
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              is_store_i,
  input  logic [2:0]        func3_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [BE_W-1:0]   be_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] ld_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata_i[8*addr_lo_i +: 8];
  assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  // Store side: enables follow the addressed lane, data is replicated to every lane.
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    if (is_store_i) begin
      case (func3_i)
        F3_B: begin
          be_o    = 4'b0001 << addr_lo_i;
          wdata_o = {4{wdata_i[7:0]}};
        end
        F3_H: begin
          be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
          wdata_o = {2{wdata_i[15:0]}};
        end
        default: begin
          be_o    = 4'b1111;
          wdata_o = wdata_i;
        end
      endcase
    end
  end

  // Load side: pick the lane and extend; unknown encodings behave as LW.
  always_comb begin
    ld_data_o = rdata_i;
    case (func3_i)
      F3_B:    ld_data_o = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      F3_H:    ld_data_o = {{(DATA_W-16){half_sel[15]}}, half_sel};
      F3_BU:   ld_data_o = {{(DATA_W-8){1'b0}}, byte_sel};
      F3_HU:   ld_data_o = {{(DATA_W-16){1'b0}}, half_sel};
      default: ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: one word-aligned bus transaction per MEM-stage access, optional MEM_LSU_MISALIGN_TRAP_EN.
// Latency: >=3 cycles request to stall release (capture, REQ, DONE); timeout after MAX_WAIT REQ cycles.
// Backpressure: lsu_stall holds the pipeline from request until DONE; bus waits on mem_ready.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int MAX_WAIT   = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [2:0]            func3,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  lsu_stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [BE_W-1:0]       mem_be,
  input  logic                  mem_ready,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  timeout_err,
  output logic                  misalign_err
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  lsu_state_t state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  we_q;
  logic                  both_q;
  logic [2:0]            func3_q;
  logic [1:0]            addr_lo_q;
  logic [DM_ADDRESS-1:0] mem_addr_q;
  logic [DATA_W-1:0]     mem_wdata_q;
  logic [BE_W-1:0]       mem_be_q;
  logic [DATA_W-1:0]     rd_data_q;
  logic                  timeout_q;
  logic                  misalign_q;

  logic                  access_vld;
  logic                  in_idle;
  logic                  timeout_hit;
  logic                  misalign_hit;
  logic                  sel_store;
  logic [2:0]            sel_func3;
  logic [1:0]            sel_addr_lo;
  logic [BE_W-1:0]       al_be;
  logic [DATA_W-1:0]     al_wdata;
  logic [DATA_W-1:0]     al_ld;

  assign access_vld  = MemRead | MemWrite;
  assign in_idle     = (state_q == ST_IDLE);
  assign timeout_hit = (state_q == ST_REQ) && !mem_ready && (cnt_q == CNT_W'(MAX_WAIT - 1));

`ifdef MEM_LSU_MISALIGN_TRAP_EN
  assign misalign_hit = misaligned(MemWrite, func3, addr[1:0]);
`else
  assign misalign_hit = 1'b0;
`endif

  // The aligner sees live inputs while capturing and the held request while waiting on the bus.
  assign sel_store   = in_idle ? MemWrite  : we_q;
  assign sel_func3   = in_idle ? func3     : func3_q;
  assign sel_addr_lo = in_idle ? addr[1:0] : addr_lo_q;

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .is_store_i (sel_store),
    .func3_i    (sel_func3),
    .addr_lo_i  (sel_addr_lo),
    .wdata_i    (wr_data),
    .rdata_i    (mem_rdata),
    .be_o       (al_be),
    .wdata_o    (al_wdata),
    .ld_data_o  (al_ld)
  );

  // State register and wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: DONE always returns to IDLE so a lingering request is not re-issued.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (access_vld) state_d = misalign_hit ? ST_DONE : ST_REQ;
      end
      ST_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_ready || timeout_hit) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; stall also covers the capture cycle in IDLE.
  always_comb begin
    lsu_stall = 1'b0;
    mem_req   = 1'b0;
    case (state_q)
      ST_IDLE: lsu_stall = access_vld;
      ST_REQ: begin
        lsu_stall = 1'b1;
        mem_req   = 1'b1;
      end
      default: begin
        lsu_stall = 1'b0;
        mem_req   = 1'b0;
      end
    endcase
  end

  // Request capture, load result and one-cycle error pulses (visible in DONE).
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q        <= 1'b0;
      both_q      <= 1'b0;
      func3_q     <= '0;
      addr_lo_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      rd_data_q   <= '0;
      timeout_q   <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      timeout_q  <= 1'b0;
      misalign_q <= 1'b0;
      if (in_idle && access_vld) begin
        we_q        <= MemWrite;
        both_q      <= MemRead & MemWrite;
        func3_q     <= func3;
        addr_lo_q   <= addr[1:0];
        mem_addr_q  <= {addr[DM_ADDRESS-1:2], 2'b00};
        mem_wdata_q <= al_wdata;
        mem_be_q    <= al_be;
        if (misalign_hit) begin
          rd_data_q  <= '0;
          misalign_q <= 1'b1;
        end
      end else if (state_q == ST_REQ) begin
        if (mem_ready) begin
          if (!we_q)       rd_data_q <= al_ld;
          else if (both_q) rd_data_q <= '0;
        end else if (timeout_hit) begin
          rd_data_q <= '0;
          timeout_q <= 1'b1;
        end
      end
    end
  end

  assign rd_data      = rd_data_q;
  assign mem_we       = we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_be       = mem_be_q;
  assign timeout_err  = timeout_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite, mem_ready;
  logic [8:0]  addr, mem_addr;
  logic [31:0] wr_data, rd_data, mem_wdata, mem_rdata;
  logic [2:0]  func3;
  logic        lsu_stall, mem_req, mem_we, timeout_err, misalign_err;
  logic [3:0]  mem_be;

  int n_cmp = 0;
  int n_bad = 0;

  // Observations of the most recent access.
  int          stall_cyc, req_cyc, to_cnt, mis_cnt;
  logic [8:0]  a_seen;
  logic [3:0]  be_seen;
  logic [31:0] wd_seen;
  logic        we_seen, stable, finished;

  mem_lsu #(.DATA_W(32), .DM_ADDRESS(9), .MAX_WAIT(15)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr),
    .wr_data(wr_data), .func3(func3), .rd_data(rd_data), .lsu_stall(lsu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .timeout_err(timeout_err), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one access until the stall drops (the DONE cycle), then one more cycle.
  // delay < 0 means mem_ready is never given.
  task automatic do_access(input logic rd, input logic wr, input logic [8:0] a,
                           input logic [31:0] wd, input logic [2:0] f3,
                           input int delay, input logic [31:0] rdat);
    MemRead = rd; MemWrite = wr; addr = a; wr_data = wd; func3 = f3;
    mem_rdata = rdat; mem_ready = 1'b0;
    stall_cyc = 0; req_cyc = 0; to_cnt = 0; mis_cnt = 0;
    stable = 1'b1; finished = 1'b0;
    a_seen = '0; be_seen = '0; wd_seen = '0; we_seen = 1'b0;
    for (int c = 0; c < 64 && !finished; c++) begin
      if (mem_req) begin
        if (req_cyc == 0) begin
          a_seen = mem_addr; be_seen = mem_be; wd_seen = mem_wdata; we_seen = mem_we;
        end else if (mem_addr !== a_seen || mem_be !== be_seen ||
                     mem_wdata !== wd_seen || mem_we !== we_seen) begin
          stable = 1'b0;
        end
        mem_ready = (delay >= 0 && req_cyc == delay);
        req_cyc++;
      end else begin
        mem_ready = 1'b0;
      end
      #1;
      if (timeout_err) to_cnt++;
      if (misalign_err) mis_cnt++;
      if (lsu_stall) stall_cyc++;
      else if (c > 0) begin
        finished = 1'b1;
        MemRead = 1'b0; MemWrite = 1'b0;
      end
      tick;
    end
    mem_ready = 1'b0;
    if (timeout_err) to_cnt++;
    if (misalign_err) mis_cnt++;
  endtask

  task automatic test_reset;
    reset = 1'b1; MemRead = 0; MemWrite = 0; addr = '0; wr_data = '0; func3 = '0;
    mem_ready = 0; mem_rdata = '0;
    tick; tick;
    reset = 1'b0;
    #1;
    n_cmp++; if (rd_data !== 32'h0) begin n_bad++; $display("FAIL rst_rd_data: got %h want 0", rd_data); end
    n_cmp++; if ({mem_req, mem_we, timeout_err, misalign_err, lsu_stall} !== 5'b0) begin n_bad++; $display("FAIL rst_ctrl: got %b want 00000", {mem_req, mem_we, timeout_err, misalign_err, lsu_stall}); end
    n_cmp++; if ({mem_addr, mem_be, mem_wdata} !== 45'h0) begin n_bad++; $display("FAIL rst_bus: got %h/%b/%h want 0", mem_addr, mem_be, mem_wdata); end
    tick;
    n_cmp++; if (lsu_stall !== 1'b0 || mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_idle: stall %b req %b want 0 0", lsu_stall, mem_req); end
  endtask

  task automatic test_store_byte;
    do_access(1'b0, 1'b1, 9'h005, 32'h0000_00AB, 3'b000, 0, 32'h0);
    n_cmp++; if (finished !== 1'b1) begin n_bad++; $display("FAIL sb_done: access never completed"); end
    n_cmp++; if (a_seen !== 9'h004) begin n_bad++; $display("FAIL sb_addr: got %h want 004", a_seen); end
    n_cmp++; if (be_seen !== 4'b0010) begin n_bad++; $display("FAIL sb_be: got %b want 0010", be_seen); end
    n_cmp++; if (wd_seen !== 32'hABAB_ABAB) begin n_bad++; $display("FAIL sb_wdata: got %h want ababab ab", wd_seen); end
    n_cmp++; if (we_seen !== 1'b1) begin n_bad++; $display("FAIL sb_we: got %b want 1", we_seen); end
    n_cmp++; if (stall_cyc != 2 || req_cyc != 1) begin n_bad++; $display("FAIL sb_timing: stall %0d req %0d want 2 1", stall_cyc, req_cyc); end
  endtask

  task automatic test_store_half_word;
    do_access(1'b0, 1'b1, 9'h00E, 32'h0000_1234, 3'b001, 0, 32'h0);
    n_cmp++; if (a_seen !== 9'h00C || be_seen !== 4'b1100) begin n_bad++; $display("FAIL sh_addr_be: got %h/%b want 00c/1100", a_seen, be_seen); end
    n_cmp++; if (wd_seen !== 32'h1234_1234) begin n_bad++; $display("FAIL sh_wdata: got %h want 12341234", wd_seen); end
    do_access(1'b0, 1'b1, 9'h010, 32'hDEAD_BEEF, 3'b010, 1, 32'h0);
    n_cmp++; if (be_seen !== 4'b1111 || wd_seen !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL sw_lane: got %b/%h want 1111/deadbeef", be_seen, wd_seen); end
  endtask

  task automatic test_loads;
    do_access(1'b1, 1'b0, 9'h007, 32'h0, 3'b000, 0, 32'h80FF_1234);
    n_cmp++; if (rd_data !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb: got %h want ffffff80", rd_data); end
    n_cmp++; if (we_seen !== 1'b0) begin n_bad++; $display("FAIL lb_we: got %b want 0", we_seen); end
    do_access(1'b1, 1'b0, 9'h007, 32'h0, 3'b100, 0, 32'h80FF_1234);
    n_cmp++; if (rd_data !== 32'h0000_0080) begin n_bad++; $display("FAIL lbu: got %h want 00000080", rd_data); end
    do_access(1'b1, 1'b0, 9'h006, 32'h0, 3'b101, 0, 32'h80FF_1234);
    n_cmp++; if (rd_data !== 32'h0000_80FF) begin n_bad++; $display("FAIL lhu: got %h want 000080ff", rd_data); end
    do_access(1'b1, 1'b0, 9'h006, 32'h0, 3'b001, 0, 32'h80FF_1234);
    n_cmp++; if (rd_data !== 32'hFFFF_80FF) begin n_bad++; $display("FAIL lh: got %h want ffff80ff", rd_data); end
    do_access(1'b1, 1'b0, 9'h004, 32'h0, 3'b000, 0, 32'h80FF_1234);
    n_cmp++; if (rd_data !== 32'h0000_0034) begin n_bad++; $display("FAIL lb_pos: got %h want 00000034", rd_data); end
  endtask

  task automatic test_lw_delay_and_hold;
    do_access(1'b1, 1'b0, 9'h100, 32'h0, 3'b010, 5, 32'h1234_5678);
    n_cmp++; if (req_cyc != 6 || stall_cyc != 7) begin n_bad++; $display("FAIL lw_wait: req %0d stall %0d want 6 7", req_cyc, stall_cyc); end
    n_cmp++; if (stable !== 1'b1 || a_seen !== 9'h100) begin n_bad++; $display("FAIL lw_stable: stable %b addr %h want 1 100", stable, a_seen); end
    n_cmp++; if (rd_data !== 32'h1234_5678) begin n_bad++; $display("FAIL lw_data: got %h want 12345678", rd_data); end
    do_access(1'b0, 1'b1, 9'h010, 32'hDEAD_BEEF, 3'b010, 0, 32'hFFFF_FFFF);
    n_cmp++; if (rd_data !== 32'h1234_5678) begin n_bad++; $display("FAIL rd_hold: got %h want 12345678", rd_data); end
  endtask

  task automatic test_timeout;
    do_access(1'b1, 1'b0, 9'h020, 32'h0, 3'b010, -1, 32'hAAAA_AAAA);
    n_cmp++; if (finished !== 1'b1) begin n_bad++; $display("FAIL to_done: access never completed"); end
    n_cmp++; if (req_cyc != 15 || stall_cyc != 16) begin n_bad++; $display("FAIL to_len: req %0d stall %0d want 15 16", req_cyc, stall_cyc); end
    n_cmp++; if (to_cnt != 1) begin n_bad++; $display("FAIL to_pulse: got %0d want 1", to_cnt); end
    n_cmp++; if (rd_data !== 32'h0) begin n_bad++; $display("FAIL to_rd: got %h want 0", rd_data); end
  endtask

  task automatic test_both_set;
    do_access(1'b1, 1'b0, 9'h008, 32'h0, 3'b010, 0, 32'h0000_0055);
    do_access(1'b1, 1'b1, 9'h008, 32'h0000_0011, 3'b010, 0, 32'h0000_0077);
    n_cmp++; if (we_seen !== 1'b1 || wd_seen !== 32'h0000_0011) begin n_bad++; $display("FAIL both_store: we %b wdata %h want 1 00000011", we_seen, wd_seen); end
    n_cmp++; if (rd_data !== 32'h0) begin n_bad++; $display("FAIL both_rd: got %h want 0", rd_data); end
  endtask

  task automatic test_misalign;
    do_access(1'b1, 1'b0, 9'h002, 32'h0, 3'b010, 0, 32'hCAFE_F00D);
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    n_cmp++; if (req_cyc != 0 || stall_cyc != 1) begin n_bad++; $display("FAIL mis_trap: req %0d stall %0d want 0 1", req_cyc, stall_cyc); end
    n_cmp++; if (mis_cnt != 1) begin n_bad++; $display("FAIL mis_pulse: got %0d want 1", mis_cnt); end
    n_cmp++; if (rd_data !== 32'h0) begin n_bad++; $display("FAIL mis_rd: got %h want 0", rd_data); end
`else
    n_cmp++; if (a_seen !== 9'h000 || be_seen !== 4'b1111) begin n_bad++; $display("FAIL mis_ignore: got %h/%b want 000/1111", a_seen, be_seen); end
    n_cmp++; if (mis_cnt != 0) begin n_bad++; $display("FAIL mis_pulse: got %0d want 0", mis_cnt); end
    n_cmp++; if (rd_data !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL mis_rd: got %h want cafef00d", rd_data); end
`endif
  endtask

  task automatic test_reset_mid;
    MemRead = 1'b1; MemWrite = 1'b0; addr = 9'h040; func3 = 3'b010; mem_ready = 1'b0;
    tick;
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL mid_req: got %b want 1", mem_req); end
    reset = 1'b1; MemRead = 1'b0;
    tick;
    reset = 1'b0;
    #1;
    n_cmp++; if (mem_req !== 1'b0 || lsu_stall !== 1'b0 || mem_addr !== 9'h0) begin n_bad++; $display("FAIL mid_abort: req %b stall %b addr %h want 0 0 000", mem_req, lsu_stall, mem_addr); end
    tick;
  endtask

  initial begin
    test_reset;
    test_store_byte;
    test_store_half_word;
    test_loads;
    test_lw_delay_and_hold;
    test_timeout;
    test_both_set;
    test_misalign;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
